psum_drain: RTL and testbench



---
 rtl/psum_drain.sv | 187 ++++++++++++++++++
 tb/tb_psum_drain.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_drain.sv
// rtl/psum_drain.sv - PE partial-sum buffer read controller with a 2-entry skid FIFO
// Optional build macro PSUM_DRAIN_RELU_EN: negative partial sums are clamped to zero on FIFO write.
module psum_drain #(
    parameter int IFMAP_WIDTH          = 18,
    parameter int IFMAP_POINTER_SIZE   = 8,
    parameter int FILTER_SIZE_REG_SIZE = 8,
    parameter int STRIDE_SIZE          = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [IFMAP_POINTER_SIZE-1:0]   ifmap_len,
    input  logic [FILTER_SIZE_REG_SIZE-1:0] filter_size,
    input  logic [STRIDE_SIZE-1:0]          stride,
    input  logic                            pe_done,
    input  logic [IFMAP_WIDTH-1:0]          Psum_out,
    output logic                            ren_Psum_buffer,
    output logic [IFMAP_WIDTH-1:0]          out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            busy,
    output logic                            drain_done,
    output logic                            cfg_err
);
    localparam int PW  = IFMAP_POINTER_SIZE;
    localparam int CW0 = (PW > FILTER_SIZE_REG_SIZE) ? PW : FILTER_SIZE_REG_SIZE;
    localparam int CW  = (CW0 > STRIDE_SIZE) ? CW0 : STRIDE_SIZE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_ARMED,
        S_DRAIN,
        S_FIN
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          s_q, s_d;
    logic [CW-1:0]          rem_q, rem_d;
    logic [PW-1:0]          n_q, n_d;
    logic [PW-1:0]          issued_q, issued_d;
    logic                   cfg_err_q, cfg_err_d;
    logic                   drain_done_q, drain_done_d;
    logic                   inflight_q;

    logic [IFMAP_WIDTH-1:0] mem_q [2];
    logic                   wr_ptr_q, rd_ptr_q;
    logic [1:0]             count_q;

    logic [CW-1:0]          len_c, flt_c, str_c, diff_c, rem_sub;
    logic                   push, pop, ren;
    logic [2:0]             occ, occ_limit;
    logic [IFMAP_WIDTH-1:0] push_data;

    // Geometry is compared in a common width so mixed parameter widths stay safe.
    assign len_c   = CW'(ifmap_len);
    assign flt_c   = CW'(filter_size);
    assign str_c   = CW'(stride);
    assign diff_c  = len_c - flt_c;
    assign rem_sub = rem_q - s_q;

    assign push      = inflight_q;
    assign out_valid = (count_q != 2'd0);
    assign pop       = out_valid & out_ready;
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

    // A read may only issue if its word is guaranteed a FIFO slot when it lands.
    assign occ       = {1'b0, count_q} + {2'b00, inflight_q};
    assign occ_limit = 3'd1 + {2'b00, pop};

`ifdef PSUM_DRAIN_RELU_EN
    assign push_data = Psum_out[IFMAP_WIDTH-1] ? '0 : Psum_out;
`else
    assign push_data = Psum_out;
`endif

    assign ren_Psum_buffer = ren;
    assign busy            = (state_q != S_IDLE);
    assign drain_done      = drain_done_q;
    assign cfg_err         = cfg_err_q;

    always_comb begin
        state_d      = state_q;
        s_d          = s_q;
        rem_d        = rem_q;
        n_d          = n_q;
        issued_d     = issued_q;
        cfg_err_d    = cfg_err_q;
        drain_done_d = 1'b0;
        ren          = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    s_d       = str_c;
                    cfg_err_d = 1'b0;
                    issued_d  = '0;
                    if ((str_c == '0) || (flt_c == '0) || (flt_c > len_c)) begin
                        cfg_err_d = 1'b1;
                        n_d       = '0;
                        rem_d     = '0;
                        state_d   = S_FIN;
                    end else begin
                        rem_d   = diff_c;
                        n_d     = PW'(1);
                        // N==1 needs no subtraction, so CALC is skipped entirely.
                        state_d = (diff_c < str_c) ? S_ARMED : S_CALC;
                    end
                end
            end
            S_CALC: begin
                rem_d = rem_sub;
                n_d   = n_q + PW'(1);
                // Look ahead on the new remainder so CALC lasts exactly N-1 cycles.
                if (rem_sub < s_q) begin
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (pe_done) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if ((issued_q < n_q) && (occ <= occ_limit)) begin
                    ren      = 1'b1;
                    issued_d = issued_q + PW'(1);
                end
                if ((issued_q == n_q) && !inflight_q && (count_q == 2'd0)) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                drain_done_d = 1'b1;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            s_q          <= '0;
            rem_q        <= '0;
            n_q          <= '0;
            issued_q     <= '0;
            cfg_err_q    <= 1'b0;
            drain_done_q <= 1'b0;
            inflight_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            s_q          <= s_d;
            rem_q        <= rem_d;
            n_q          <= n_d;
            issued_q     <= issued_d;
            cfg_err_q    <= cfg_err_d;
            drain_done_q <= drain_done_d;
            inflight_q   <= ren;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_psum_drain.sv
// tb/tb_psum_drain.sv - self-checking bench for psum_drain against a job-level reference model
module tb_psum_drain;
    localparam int W = 18;
`ifdef PSUM_DRAIN_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [7:0]   ifmap_len = '0;
    logic [7:0]   filter_size = '0;
    logic [2:0]   stride = '0;
    logic         pe_done = 1'b0;
    logic [W-1:0] Psum_out = '0;
    logic         ren_Psum_buffer;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic         busy;
    logic         drain_done;
    logic         cfg_err;

    psum_drain dut (
        .clk(clk), .rst(rst), .start(start), .ifmap_len(ifmap_len),
        .filter_size(filter_size), .stride(stride), .pe_done(pe_done),
        .Psum_out(Psum_out), .ren_Psum_buffer(ren_Psum_buffer), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
        .drain_done(drain_done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rdy_mode = 0;
    int phase = 0;
    int ren_cnt, xfer_cnt, done_cnt, first_ren, last_ren, done_cyc, out_cnt;
    bit done_seen;
    bit rd_req = 1'b0;
    bit stall_q = 1'b0;
    logic [W-1:0] stall_data;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    logic [W-1:0] psum_src[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] relu(input logic [W-1:0] v);
        if (RELU && v[W-1]) return '0;
        return v;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // PE buffer model: a read seen in one cycle presents its word during the next.
    always @(posedge clk) begin
        logic [W-1:0] v;
        #1;
        if (rd_req) begin
            if (psum_src.size() > 0) v = psum_src.pop_front();
            else v = W'($urandom);
            Psum_out = v;
            exp_q.push_back(relu(v));
        end else begin
            Psum_out = W'($urandom);
        end
    end

    always @(posedge clk) begin
        #1;
        phase++;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (phase % 3 == 0);
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clk) begin
        bit pop;
        if (rst) begin
            rd_req  = 1'b0;
            stall_q = 1'b0;
            out_cnt = 0;
        end else begin
            pop    = out_valid && out_ready;
            rd_req = ren_Psum_buffer;
            check("valid_has_data", (!out_valid || exp_q.size() > 0), 1);
            if (stall_q) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, stall_data);
            end
            if (ren_Psum_buffer) begin
                check("ren_space", (out_cnt - int'(pop) <= 1), 1);
                ren_cnt++;
                if (first_ren < 0) first_ren = cyc;
                last_ren = cyc;
            end
            out_cnt = out_cnt + int'(ren_Psum_buffer) - int'(pop);
            if (pop) begin
                xfer_cnt++;
                got_q.push_back(out_data);
                if (exp_q.size() == 0) check("underflow", 1, 0);
                else check("out_data", out_data, exp_q.pop_front());
            end
            stall_q    = out_valid && !out_ready;
            stall_data = out_data;
            if (drain_done) begin
                done_cnt++;
                done_cyc  = cyc;
                done_seen = 1'b1;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ren"}, ren_Psum_buffer, 0);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_data"}, out_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, drain_done, 0);
        check({tag, "_cfg_err"}, cfg_err, 0);
    endtask

    // rst_drain != 0 asserts rst during that (1-based) DRAIN cycle; lit_n >= 0 pins the read count.
    task automatic run_job(input int L, input int F, input int S, input int mode,
                           input int rst_drain, input int lit_n);
        bit exp_err, spur, aborted;
        int exp_n, delay, t0, k_rst;
        exp_err = (S == 0) || (F == 0) || (F > L);
        exp_n   = exp_err ? 0 : (L - F) / S + 1;
        delay   = $urandom_range(0, 3);
        spur    = (exp_n >= 3) && ($urandom_range(0, 1) == 1);
        k_rst   = (rst_drain != 0) ? exp_n + delay + rst_drain : -1;
        aborted = 1'b0;
        rdy_mode = mode;
        ren_cnt = 0; xfer_cnt = 0; done_cnt = 0; first_ren = -1; last_ren = -1;
        done_cyc = -1; done_seen = 1'b0;
        got_q.delete();
        @(posedge clk); #1;
        start = 1'b1; ifmap_len = 8'(L); filter_size = 8'(F); stride = 3'(S);
        t0 = cyc;
        for (int k = 1; k < 400; k++) begin
            @(posedge clk); #1;
            start   = 1'b0;
            pe_done = (k == exp_n + delay) || (spur && k == 1);
            if (k == 1) begin
                check("busy_after_start", busy, 1);
                check("cfg_err_after_start", cfg_err, exp_err);
            end
            if (k == k_rst) rst = 1'b1;
            if (k == k_rst + 1) begin
                rst = 1'b0;
                check_reset_outputs("midrst");
                exp_q.delete();
                aborted = 1'b1;
                break;
            end
            if (done_seen) break;
        end
        pe_done = 1'b0;
        if (aborted) begin
            repeat (4) @(posedge clk);
            #1;
            check("midrst_no_done", done_cnt, 0);
            check("midrst_idle", busy, 0);
            return;
        end
        if (!done_seen) begin
            check("timeout_drain_done", 0, 1);
            return;
        end
        check("busy_after_done", busy, 0);
        check("cfg_err_final", cfg_err, exp_err);
        check("ren_count", ren_cnt, exp_n);
        check("xfer_count", xfer_cnt, exp_n);
        check("done_pulses", done_cnt, 1);
        check("model_empty", exp_q.size(), 0);
        if (lit_n >= 0) check("ren_count_literal", ren_cnt, lit_n);
        if (exp_err) begin
            check("err_done_latency", done_cyc - t0, 2);
        end else begin
            check("first_ren_latency", first_ren - t0, exp_n + delay + 1);
            if (mode == 0) check("ren_back_to_back", last_ren - first_ren, exp_n - 1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("reset");

        for (int i = 0; i < 6; i++) psum_src.push_back(W'(10 + i));
        run_job(8, 3, 1, 0, 0, 6);
        check("seq_len", got_q.size(), 6);
        for (int i = 0; i < got_q.size(); i++) check("seq_literal", got_q[i], 10 + i);

        run_job(8, 3, 2, 0, 0, 3);
        run_job(8, 9, 1, 0, 0, 0);
        run_job(8, 9, 0, 0, 0, 0);
        run_job(8, 3, 1, 0, 0, 6);
        run_job(8, 3, 1, 1, 0, 6);
        run_job(8, 3, 1, 0, 3, -1);
        run_job(8, 3, 1, 0, 0, 6);

        psum_src.delete();
        psum_src.push_back(18'h3FFFF);
        psum_src.push_back(18'h00005);
        run_job(2, 1, 1, 0, 0, 2);
        check("relu_len", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("relu_first", got_q[0], RELU ? 32'h0 : 32'h3FFFF);
            check("relu_second", got_q[1], 32'h5);
        end

        for (int j = 0; j < 30; j++) begin
            int L, F, S;
            L = $urandom_range(1, 40);
            F = $urandom_range(0, L + 2);
            S = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 7);
            run_job(L, F, S, $urandom_range(0, 2), 0, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
